// File: rtl/opr_sequencer_pkg.sv
// Shared types, decode constants and step-ordering helpers for the
// operate-microinstruction sequencer.
package opr_pkg;

    // IDLE..S_ROT2 are numbered in group-1 issue order so next_step can scan by value.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        S_CLA  = 4'd1,
        S_CLL  = 4'd2,
        S_CMA  = 4'd3,
        S_CML  = 4'd4,
        S_IAC  = 4'd5,
        S_ROT1 = 4'd6,
        S_ROT2 = 4'd7,
        S_SKIP = 4'd8,
        S_DONE = 4'd9
    } state_e;

    localparam logic [2:0] OPR_OPCODE = 3'b111;
    localparam int GROUP_BIT = 8;

    localparam int G1_CLA = 7;
    localparam int G1_CLL = 6;
    localparam int G1_CMA = 5;
    localparam int G1_CML = 4;
    localparam int G1_RAR = 3;
    localparam int G1_RAL = 2;
    localparam int G1_BSW = 1;
    localparam int G1_IAC = 0;

    localparam int G2_CLA = 7;
    localparam int G2_SMA = 6;
    localparam int G2_SZA = 5;
    localparam int G2_SNL = 4;
    localparam int G2_REV = 3;
    localparam int G2_G3  = 0;

    function automatic logic is_group1(input logic [11:0] ir);
        return (ir[11:9] == OPR_OPCODE) && !ir[GROUP_BIT];
    endfunction

    function automatic logic is_group2(input logic [11:0] ir);
        return (ir[11:9] == OPR_OPCODE) && ir[GROUP_BIT] && !ir[G2_G3];
    endfunction

    function automatic logic skip_eval(input logic [11:0] ir, input logic accminus,
                                       input logic acczero, input logic cyout);
        return ((ir[G2_SMA] & accminus) | (ir[G2_SZA] & acczero) | (ir[G2_SNL] & cyout))
               ^ ir[G2_REV];
    endfunction

    function automatic state_e next_step(input state_e cur, input logic [11:0] ir);
        logic [7:0] en;
        logic       rot;
        state_e     nxt;
        nxt = S_DONE;
        en  = '0;
        // Contradictory RAR+RAL suppresses both rotate steps.
        rot = ir[G1_RAR] ^ ir[G1_RAL];
        if (is_group1(ir)) begin
            en = {rot & ir[G1_BSW], rot, ir[G1_IAC], ir[G1_CML], ir[G1_CMA],
                  ir[G1_CLL], ir[G1_CLA], 1'b0};
            for (int k = 7; k >= 1; k--) begin
                if (en[k] && (k > int'(cur))) nxt = state_e'(k[3:0]);
            end
        end else if (is_group2(ir)) begin
            if (cur == IDLE) nxt = S_SKIP;
            else if ((cur == S_SKIP) && ir[G2_CLA]) nxt = S_CLA;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/opr_sequencer_if.sv
// Start/status/strobe bundle between the main control FSM, the sequencer
// and the accumulator/carry block.
interface opr_sequencer_if;
    logic        start;
    logic [11:0] ir;
    logic        accminus;
    logic        acczero;
    logic        cyout;
    logic        clearacc;
    logic        clearcy;
    logic        compacc;
    logic        compcy;
    logic        RL;
    logic        RR;
    logic        iac;
    logic        busy;
    logic        done;
    logic        skip;

    modport master (
        output start, ir, accminus, acczero, cyout,
        input  clearacc, clearcy, compacc, compcy, RL, RR, iac, busy, done, skip
    );

    modport slave (
        input  start, ir, accminus, acczero, cyout,
        output clearacc, clearcy, compacc, compcy, RL, RR, iac, busy, done, skip
    );
endinterface

// File: rtl/opr_sequencer.sv
// Turns a latched OPR instruction into one accumulator/carry strobe per cycle,
// evaluating the group-2 skip condition on the way.
module opr_sequencer
    import opr_pkg::*;
(
    input logic            clk,
    input logic            rst,
    opr_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic [11:0] ir_q, ir_d;
    logic        skip_q, skip_d;
    logic [6:0]  strobe_q, strobe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rotate_d;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        skip_d  = skip_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ir_d    = bus.ir;
                    skip_d  = 1'b0;
                    state_d = next_step(IDLE, bus.ir);
                end
            end
            S_DONE: state_d = IDLE;
            default: begin
                if (state_q == S_SKIP)
                    skip_d = skip_eval(ir_q, bus.accminus, bus.acczero, bus.cyout);
                state_d = next_step(state_q, ir_q);
            end
        endcase

        // Outputs are decoded from the upcoming state so they register alongside it.
        rotate_d = (state_d == S_ROT1) || (state_d == S_ROT2);
        strobe_d = {state_d == S_CLA, state_d == S_CLL, state_d == S_CMA, state_d == S_CML,
                    rotate_d & ir_d[G1_RAL], rotate_d & ir_d[G1_RAR], state_d == S_IAC};
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            skip_q   <= 1'b0;
            strobe_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            skip_q   <= skip_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign {bus.clearacc, bus.clearcy, bus.compacc, bus.compcy,
            bus.RL, bus.RR, bus.iac} = strobe_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.skip = skip_q;

endmodule

// File: tb/tb_opr_sequencer.sv
// Self-checking bench for opr_sequencer: directed vector table, random
// instructions against a step-list reference model, and a mid-sequence reset.
module tb_opr_sequencer;

    logic clk = 1'b0;
    logic rst;

    opr_sequencer_if bus();

    opr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Strobe vector layout: {clearacc, clearcy, compacc, compcy, RL, RR, iac}
    localparam logic [6:0] ST_CLA = 7'b1000000;
    localparam logic [6:0] ST_CLL = 7'b0100000;
    localparam logic [6:0] ST_CMA = 7'b0010000;
    localparam logic [6:0] ST_CML = 7'b0001000;
    localparam logic [6:0] ST_RL  = 7'b0000100;
    localparam logic [6:0] ST_RR  = 7'b0000010;
    localparam logic [6:0] ST_IAC = 7'b0000001;

    typedef struct {
        logic [11:0] ir;
        logic        m;
        logic        z;
        logic        c;
        logic        rePulse;
        int          doneCyc;
        logic        skip;
    } vec_t;

    int         compared   = 0;
    int         mismatched = 0;
    logic [8:0] obsQ[$];
    logic [8:0] expQ[$];
    logic       expSkip;
    vec_t       tbl[12];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.clearacc, bus.clearcy, bus.compacc, bus.compcy, bus.RL, bus.RR, bus.iac};
    endfunction

    // Expected per-cycle {strobes, busy, done} list built straight from the instruction bits.
    task automatic refModel(input logic [11:0] ir, input logic m, input logic z, input logic c);
        logic [6:0] steps[$];
        logic [6:0] rs;
        expQ.delete();
        expSkip = 1'b0;
        if (ir[11:9] == 3'b111 && !ir[8]) begin
            if (ir[7]) steps.push_back(ST_CLA);
            if (ir[6]) steps.push_back(ST_CLL);
            if (ir[5]) steps.push_back(ST_CMA);
            if (ir[4]) steps.push_back(ST_CML);
            if (ir[0]) steps.push_back(ST_IAC);
            if (ir[3] != ir[2]) begin
                rs = ir[2] ? ST_RL : ST_RR;
                steps.push_back(rs);
                if (ir[1]) steps.push_back(rs);
            end
        end else if (ir[11:9] == 3'b111 && ir[8] && !ir[0]) begin
            steps.push_back(7'b0);
            if (ir[7]) steps.push_back(ST_CLA);
            expSkip = ((ir[6] & m) | (ir[5] & z) | (ir[4] & c)) ^ ir[3];
        end
        foreach (steps[i]) expQ.push_back({steps[i], 2'b10});
        expQ.push_back({7'b0, 2'b11});
    endtask

    task automatic applyStimulus(input logic [11:0] irv, input logic m, input logic z,
                                 input logic c, input logic rePulse,
                                 output int doneCyc, output logic skv);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.ir       = irv;
        bus.accminus = m;
        bus.acczero  = z;
        bus.cyout    = c;
        obsQ.delete();
        doneCyc = 0;
        skv     = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            obsQ.push_back({strobes(), bus.busy, bus.done});
            if (bus.done) begin
                doneCyc = k;
                skv     = bus.skip;
                break;
            end
            if (rePulse) bus.ir = 12'o7240;
            else         bus.start = 1'b0;
        end
        if (rePulse) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic runOp(input string name, input logic [11:0] irv, input logic m, input logic z,
                         input logic c, input logic rePulse, input logic checkTbl,
                         input int tblDone, input logic tblSkip);
        int   doneCyc;
        logic skv;
        refModel(irv, m, z, c);
        applyStimulus(irv, m, z, c, rePulse, doneCyc, skv);
        checkOutput({name, " length"}, 16'(obsQ.size()), 16'(expQ.size()));
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s cyc%0d", name, i + 1), 16'(obsQ[i]), 16'(expQ[i]));
        checkOutput({name, " skip"}, 16'(skv), 16'(expSkip));
        if (checkTbl) begin
            checkOutput({name, " done cycle"}, 16'(doneCyc), 16'(tblDone));
            checkOutput({name, " table skip"}, 16'(skv), 16'(tblSkip));
        end
        @(negedge clk);
        checkOutput({name, " idle"}, 16'({strobes(), bus.busy, bus.done, bus.skip}),
                    16'({9'b0, expSkip}));
    endtask

    initial begin
        logic [11:0] rir;
        logic [2:0]  opc;

        tbl[0]  = '{12'o7240, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        tbl[1]  = '{12'o7006, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        tbl[2]  = '{12'o7014, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        tbl[3]  = '{12'o7000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        tbl[4]  = '{12'o7401, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0};
        tbl[5]  = '{12'o7640, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1};
        tbl[6]  = '{12'o7640, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        tbl[7]  = '{12'o7510, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        tbl[8]  = '{12'o7510, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1};
        tbl[9]  = '{12'o7410, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1};
        tbl[10] = '{12'o7410, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1};
        tbl[11] = '{12'o7301, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0};

        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.ir       = '0;
        bus.accminus = 1'b0;
        bus.acczero  = 1'b0;
        bus.cyout    = 1'b0;
        #12;
        checkOutput("reset state", 16'({strobes(), bus.busy, bus.done, bus.skip}), 16'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            runOp($sformatf("vec%0d %o", i, tbl[i].ir), tbl[i].ir, tbl[i].m, tbl[i].z,
                  tbl[i].c, tbl[i].rePulse, 1'b1, tbl[i].doneCyc, tbl[i].skip);

        // Reset dropped in the middle of 7240, between the clearacc and compacc cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.ir    = 12'o7240;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("midreset cyc1", 16'({strobes(), bus.busy, bus.done}),
                    16'({ST_CLA, 2'b10}));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset async", 16'({strobes(), bus.busy, bus.done, bus.skip}), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("postreset quiet%0d", k),
                        16'({strobes(), bus.busy, bus.done, bus.skip}), 16'h0);
        end
        runOp("postreset nop", 12'o7000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);

        for (int n = 0; n < 250; n++) begin
            opc = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
            rir = {opc, 9'($urandom)};
            runOp($sformatf("rand%0d %o", n, rir), rir, 1'($urandom), 1'($urandom),
                  1'($urandom), 1'b0, 1'b0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
